beat_packer: RTL and testbench

Downstream consumer of a narrow ready/valid queue. It packs RATIO consecutive narrow beats into one wide beat for the vector datapath. An input beat flagged last closes the wide word early, and a per-lane mask marks which lanes hold valid data. It is fully ready/valid on both sides and sustains one input beat per cycle with no bubbles at word boundaries.

---
 rtl/beat_packer.sv | 140 ++++++++++++++
 tb/tb_beat_packer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/beat_packer.sv
// rtl/beat_packer.sv - packs RATIO narrow ready/valid beats into one wide masked word
// Optional idle timeout flush: define BEAT_PACKER_TIMEOUT_EN (adds TIMEOUT_CYCLES).
module beat_packer #(
  parameter int NARROW_W = 32,
  parameter int RATIO    = 4
`ifdef BEAT_PACKER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NARROW_W-1:0]          in_data_i,
  input  logic                         in_last_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NARROW_W*RATIO-1:0]    out_data_o,
  output logic [RATIO-1:0]             out_mask_o,
  output logic                         out_last_o
);

  if (RATIO < 2) begin : g_ratio_check
    $fatal(1, "beat_packer: RATIO must be >= 2");
  end

  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_valid;
  logic [NARROW_W*RATIO-1:0]   r_data;
  logic [RATIO-1:0]            r_mask;
  logic                        r_last;
  logic                        w_in_fire;
  logic                        w_out_fire;
  logic                        w_timeout;

  // While a word is held, a new beat can only enter if the held word leaves this cycle.
  assign in_ready_o  = (r_state == S_FILL) ? 1'b1 : out_ready_i;
  assign w_in_fire   = in_valid_i & in_ready_o;
  assign w_out_fire  = r_valid & out_ready_i;

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_mask_o  = r_mask;
  assign out_last_o  = r_last;

`ifdef BEAT_PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle;

  // Idle counter: counts stalled cycles of a partially filled word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle <= '0;
    end else if (w_in_fire || r_state != S_FILL) begin
      r_idle <= '0;
    end else if (r_cnt != '0) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_FILL) && (r_cnt != '0) && !w_in_fire &&
                     (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Packing FSM: fill lanes in order, hold the finished word until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mask  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            for (int k = 0; k < RATIO; k++) begin
              if (r_cnt == CNT_W'(k)) begin
                r_data[k*NARROW_W +: NARROW_W] <= in_data_i;
                r_mask[k]                      <= 1'b1;
              end
            end
            r_last <= in_last_i;
            if (r_cnt == CNT_MAX || in_last_i) begin
              r_state <= S_HOLD;
              r_valid <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= S_HOLD;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_HOLD: begin
          if (w_out_fire) begin
            if (w_in_fire) begin
              // Back-to-back: the incoming beat starts a fresh word in lane 0.
              r_data <= {{(NARROW_W*(RATIO-1)){1'b0}}, in_data_i};
              r_mask <= RATIO'(1);
              r_last <= in_last_i;
              if (in_last_i) begin
                r_cnt <= '0;
              end else begin
                r_state <= S_FILL;
                r_valid <= 1'b0;
                r_cnt   <= CNT_W'(1);
              end
            end else begin
              r_state <= S_FILL;
              r_valid <= 1'b0;
              r_data  <= '0;
              r_mask  <= '0;
              r_last  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_packer.sv
// tb/tb_beat_packer.sv - self-checking bench for beat_packer against a queue-based word model
module tb_beat_packer;

  localparam int NW = 32;
  localparam int R  = 4;
  localparam int W  = NW * R;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [R-1:0]  out_mask;
  logic          out_last;

  beat_packer #(.NARROW_W(NW), .RATIO(R)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_mask_o  (out_mask),
    .out_last_o  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: beats collected so far for the word being built, plus the word waiting for the consumer.
  logic [NW-1:0] part[$];
  bit            hv;
  logic [W-1:0]  hdata;
  logic [R-1:0]  hmask;
  bit            hlast;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    part.delete();
    hv    = 0;
    hdata = '0;
    hmask = '0;
    hlast = 0;
  endtask

  task automatic model_update();
    bit exp_r;
    if (!rst_n) begin
      model_clear();
      return;
    end
    exp_r = !hv || out_ready;
    if (hv && out_ready) hv = 0;
    if (in_valid && exp_r) begin
      part.push_back(in_data);
      if (part.size() == R || in_last) begin
        hdata = '0;
        for (int k = 0; k < part.size(); k++) hdata[k*NW +: NW] = part[k];
        hmask = R'((1 << part.size()) - 1);
        hlast = in_last;
        hv    = 1;
        part.delete();
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", W'(in_ready), W'(!hv || out_ready));
    chk("out_valid", W'(out_valid), W'(hv));
    if (hv) begin
      chk("out_data", out_data, hdata);
      chk("out_mask", W'(out_mask), W'(hmask));
      chk("out_last", W'(out_last), W'(hlast));
    end
  endtask

  // One cycle: model absorbs the edge, new inputs are driven mid-cycle, then outputs are checked.
  task automatic step(input bit v, input logic [NW-1:0] d, input bit l, input bit r);
    @(posedge clk);
    model_update();
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    compare();
  endtask

  int words;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    model_clear();
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_mask", W'(out_mask), '0);
    chk("rst_out_last", W'(out_last), '0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full word of four beats
    step(1, 32'hA0, 0, 1);
    step(1, 32'hA1, 0, 1);
    step(1, 32'hA2, 0, 1);
    step(1, 32'hA3, 0, 1);
    step(0, 0, 0, 1);
    chk("t1_valid", W'(out_valid), W'(1));
    chk("t1_data", out_data, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("t1_mask", W'(out_mask), W'(4'b1111));
    chk("t1_last", W'(out_last), W'(0));

    // Early close on last, then a stalled consumer
    step(1, 32'h11, 0, 1);
    step(1, 32'h22, 1, 1);
    step(0, 0, 0, 0);
    chk("t2_data", out_data, 128'h00000000_00000000_00000022_00000011);
    chk("t2_mask", W'(out_mask), W'(4'b0011));
    chk("t2_last", W'(out_last), W'(1));
    for (int i = 0; i < 5; i++) begin
      step(1, 32'hEE, 0, 0);
      chk("t3_in_ready", W'(in_ready), W'(0));
      chk("t3_stable", out_data, 128'h00000000_00000000_00000022_00000011);
    end
    step(1, 32'h55, 0, 1);
    step(1, 32'h56, 0, 1);
    chk("t3_drained", W'(out_valid), W'(0));
    chk("t3_lane0", out_data, 128'h55);
    chk("t3_mask", W'(out_mask), W'(4'b0001));
    step(1, 32'h57, 0, 1);
    step(1, 32'h58, 0, 1);
    step(0, 0, 0, 1);
    chk("t3_word", out_data, 128'h00000058_00000057_00000056_00000055);
    chk("t3_word_mask", W'(out_mask), W'(4'b1111));

    // Streaming: 12 beats, 3 words, no backpressure
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    words = 0;
    for (int i = 0; i < 13; i++) begin
      if (i < 12) step(1, NW'(32'hC0 + i), 0, 1);
      else        step(0, 0, 0, 1);
      if (i < 12) chk("t4_in_ready", W'(in_ready), W'(1));
      if (out_valid && out_ready) words++;
    end
    chk("t4_words", W'(words), W'(3));

    // Reset discards a partial word
    step(0, 0, 0, 1);
    step(1, 32'hB0, 0, 1);
    step(1, 32'hB1, 0, 1);
    step(0, 0, 0, 1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("t5_rst_valid", W'(out_valid), W'(0));
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t5_rst_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    step(1, 32'hD0, 0, 1);
    step(1, 32'hD1, 0, 1);
    step(1, 32'hD2, 0, 1);
    step(1, 32'hD3, 0, 1);
    step(0, 0, 0, 1);
    chk("t5_data", out_data, 128'h000000D3_000000D2_000000D1_000000D0);
    chk("t5_mask", W'(out_mask), W'(4'b1111));

    // Randomized traffic with random backpressure and early closes
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) < 7);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
